csa_seq_ctrl: RTL and testbench
===============================

Name: csa_seq_ctrl

Overview:
- Multi-cycle sequencer that computes a WIDTH-bit add by time-multiplexing one external CHUNK-bit carry-select adder slice, least-significant chunk first.
- Carry out of each chunk is registered and fed back as carry in of the next chunk.
- Sits between operand registers and the shared carry-select adder slice. It provides a start/busy/done handshake and an atomically updated result.

Parameters:
- WIDTH, 32, total operand width in bits. Must be an integer multiple of CHUNK.
- CHUNK, 8, width of the external adder slice in bits.
- NCHUNK, WIDTH/CHUNK (derived localparam), number of RUN cycles per add. Must be ≥ 1.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a new add. Sampled only in IDLE.
- a  in  WIDTH  operand A. Captured on the edge that accepts start.
- b  in  WIDTH  operand B. Captured on the edge that accepts start.
- cin  in  1  carry into bit 0. Captured on the edge that accepts start.
- add_a  out  CHUNK  operand chunk driven to the adder slice.
- add_b  out  CHUNK  operand chunk driven to the adder slice.
- add_cin  out  1  carry in to the adder slice.
- add_s  in  CHUNK  sum from the adder slice. Combinational, valid in the same cycle.
- add_cout  in  1  carry out from the adder slice.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  registered result.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; idx=0; carry reg=0; operand regs=0; busy=0; done=0; sum=0; cout=0; ovf=0.
- Reset mid-operation aborts immediately. No done pulse is produced and sum/cout/ovf clear to 0.
- States: IDLE, RUN, DONE. State register is clocked; transitions happen only on rising edges.
- IDLE:
  - add_a=0, add_b=0, add_cin=0.
  - If start=1 at an edge: latch a, b, cin; set idx=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy=1), in the cycle where idx=k:
  - add_a = a_reg[k*CHUNK +: CHUNK]; add_b = b_reg[k*CHUNK +: CHUNK].
  - add_cin = cin_reg when k=0, else carry reg.
  - At the edge: work[k*CHUNK +: CHUNK] <= add_s; carry <= add_cout.
  - If k=NCHUNK-1: sum <= the completed work value, including this chunk. cout <= add_cout. ovf <= (a_reg[MSB]==b_reg[MSB]) && (new sum[MSB] != a_reg[MSB]). Go to DONE.
  - Otherwise idx <= k+1.
- DONE: done=1 and busy=0 for exactly one cycle; adder inputs are driven to 0. Unconditionally go to IDLE at the next edge.
- Latency: start accepted at edge E0. RUN occupies the NCHUNK cycles after E0. done is high during the cycle after edge E_NCHUNK. Default: 4 RUN cycles, done in cycle 5. Accepted starts are at least NCHUNK+2 cycles apart.
- start in RUN or DONE is ignored, not queued. Operand changes after acceptance have no effect.
- sum/cout/ovf change only at the RUN→DONE edge or on reset. They hold their values through IDLE and through the next operation until that operation completes.
- Width rules:
  - The sum is taken mod 2^WIDTH.
  - The carry chain spans all chunks, so wrap-around from an all-ones input with cin=1 produces sum=0, cout=1.
  - idx counter width is clog2(NCHUNK), minimum 1 bit.
- NCHUNK=1 case: a single RUN cycle, then DONE.
- Simultaneous rst and start: rst wins.

Test Plan:
- Reset: assert rst for 2 cycles with start=1 → busy=0, done=0, sum=0, cout=0, ovf=0, and no operation starts.
- Basic add: a=0x0000_1234, b=0x0000_0001, cin=0, start pulse → busy high for 4 cycles, then done pulse; sum=0x0000_1235, cout=0, ovf=0. add_cin=0 in every RUN cycle.
- Ripple across chunks: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 → add_cin sequence 1,1,1,1; sum=0x0000_0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001, cin=0 → sum=0x8000_0000, cout=0, ovf=1. Second case: a=0x8000_0000, b=0x8000_0000 → sum=0, cout=1, ovf=1.
- Ignored start and held result: hold start=1 continuously with changing a/b → an operation is accepted only in IDLE, using the operands present at that edge. sum holds its prior value during RUN and updates only when done pulses.
- Mid-operation reset: rst=1 in the 2nd RUN cycle of a=0x1111_1111, b=0x2222_2222 → next cycle state=IDLE, no done pulse, sum=0. A new start afterwards completes correctly with sum=0x3333_3333.

Source files
------------

// File: rtl/csa_seq_ctrl.sv
// Sequencer that forms a WIDTH-bit add from one shared CHUNK-bit adder slice.
// It works one chunk per cycle, least-significant chunk first, and registers the carry between chunks.
module csa_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] add_a,
  output logic [CHUNK-1:0] add_b,
  output logic             add_cin,
  input  logic [CHUNK-1:0] add_s,
  input  logic             add_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             cin_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nxt;
  logic             last;

  // Two's-complement overflow: like-signed operands giving an opposite-signed result.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    busy      = 1'b0;
    done      = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    last      = (idx == LAST_IDX);
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = a_reg[int'(idx)*CHUNK +: CHUNK];
        add_b   = b_reg[int'(idx)*CHUNK +: CHUNK];
        add_cin = (idx == '0) ? cin_reg : carry;
        work_nxt[int'(idx)*CHUNK +: CHUNK] = add_s;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      cin_reg <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      work    <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            cin_reg <= cin;
            idx     <= '0;
          end
        end
        RUN: begin
          work  <= work_nxt;
          carry <= add_cout;
          // Result registers update together, only on the final chunk.
          if (last) begin
            sum  <= work_nxt;
            cout <= add_cout;
            ovf  <= signed_ovf(a_reg[WIDTH-1], b_reg[WIDTH-1], work_nxt[WIDTH-1]);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_seq_ctrl.sv
// Bench for csa_seq_ctrl: the bench drives the external adder slice and runs a behavioural model.
// It checks every cycle against that model and also pins directed cases to literal values.
module tb_csa_seq_ctrl;

  localparam int W = 32;
  localparam int C = 8;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic [C-1:0] add_a;
  logic [C-1:0] add_b;
  logic         add_cin;
  logic [C-1:0] add_s;
  logic         add_cout;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // The shared carry-select slice, modelled as a plain adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{C{1'b0}}, add_cin};

  csa_seq_ctrl #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i), .cin(cin_i),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: phase 0 = idle, 1..N = run cycle (chunk phase-1), N+1 = done cycle.
  int           phase = 0;
  logic [W-1:0] ma = '0, mb = '0;
  logic         mcin = 1'b0;
  logic [W-1:0] exp_sum = '0;
  logic         exp_cout = 1'b0, exp_ovf = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      phase = 0; exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        ma = a_i; mb = b_i; mcin = cin_i; phase = 1;
      end
    end else if (phase == N) begin
      longint unsigned u;
      longint          s;
      u = 64'(ma) + 64'(mb) + 64'(mcin);
      s = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mcin);
      exp_sum  = u[W-1:0];
      exp_cout = u[W];
      exp_ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      phase = N + 1;
    end else if (phase == N + 1) begin
      phase = 0;
    end else begin
      phase = phase + 1;
    end
  end

  always @(negedge clk) begin
    longint unsigned ea, eb, ec, m;
    int k;
    ea = 0; eb = 0; ec = 0;
    if (phase >= 1 && phase <= N) begin
      k  = phase - 1;
      ea = (64'(ma) >> (k*C)) & ((64'd1 << C) - 1);
      eb = (64'(mb) >> (k*C)) & ((64'd1 << C) - 1);
      m  = (64'd1 << (k*C)) - 1;
      ec = (((64'(ma) & m) + (64'(mb) & m) + 64'(mcin)) >> (k*C)) & 64'd1;
    end
    chk("busy",    64'(busy),    64'(phase >= 1 && phase <= N));
    chk("done",    64'(done),    64'(phase == N + 1));
    chk("add_a",   64'(add_a),   ea);
    chk("add_b",   64'(add_b),   eb);
    chk("add_cin", 64'(add_cin), ec);
    chk("sum",     64'(sum),     64'(exp_sum));
    chk("cout",    64'(cout),    64'(exp_cout));
    chk("ovf",     64'(ovf),     64'(exp_ovf));
  end

  // Starts an add, waits (bounded) for done and checks literal results; entered and left at posedge+2.
  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic [W-1:0] es, input logic ec, input logic eo,
                        input logic [3:0] ecins);
    int   nbusy;
    logic seen;
    logic [3:0] cins;
    a_i = ta; b_i = tb; cin_i = tc; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; a_i = $urandom; b_i = $urandom; cin_i = 1'b1;
    nbusy = 0; seen = 1'b0; cins = '0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (busy) begin
        if (nbusy < 4) cins[nbusy] = add_cin;
        nbusy++;
      end
      if (done) seen = 1'b1;
    end
    chk({nm, " done_seen"}, 64'(seen), 64'd1);
    chk({nm, " busy_cycles"}, 64'(nbusy), 64'(N));
    chk({nm, " sum"}, 64'(sum), 64'(es));
    chk({nm, " cout"}, 64'(cout), 64'(ec));
    chk({nm, " ovf"}, 64'(ovf), 64'(eo));
    chk({nm, " cin_seq"}, 64'(cins), 64'(ecins));
    @(posedge clk); #2;
  endtask

  initial begin
    logic no_done;
    rst = 1'b1; start = 1'b1; a_i = 32'hDEAD_BEEF; b_i = 32'h1234_5678; cin_i = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst sum",  64'(sum),  64'd0);
    chk("rst cout", 64'(cout), 64'd0);
    chk("rst ovf",  64'(ovf),  64'd0);
    #1; rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("rst no_start", 64'(busy), 64'd0);
    #1;

    run_op("basic",  32'h0000_1234, 32'h0000_0001, 1'b0, 32'h0000_1235, 1'b0, 1'b0, 4'b0000);
    run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 4'b1111);
    run_op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 4'b1110);
    run_op("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 4'b0000);
    run_op("wrap",   32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 4'b1110);

    // start held high with operands changing each cycle: accepts land on edges 0 and 6
    cin_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      a_i = 32'(32'h10 * (i + 1)); b_i = 32'(i + 1); start = 1'b1;
      @(posedge clk); #1;
      if (i == 4) begin
        chk("held done1", 64'(done), 64'd1);
        chk("held sum1",  64'(sum),  64'h11);
      end
      if (i == 8) begin
        chk("held busy2", 64'(busy), 64'd1);
        chk("held sum_hold", 64'(sum), 64'h11);
      end
      if (i == 10) begin
        chk("held done2", 64'(done), 64'd1);
        chk("held sum2",  64'(sum),  64'h77);
      end
      #1;
    end
    start = 1'b0;
    @(posedge clk); #2;

    // reset during the second RUN cycle
    a_i = 32'h1111_1111; b_i = 32'h2222_2222; cin_i = 1'b0; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst sum",  64'(sum),  64'd0);
    #1; rst = 1'b0;
    no_done = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || busy) no_done = 1'b0;
    end
    chk("midrst quiet", 64'(no_done), 64'd1);
    @(posedge clk); #2;
    run_op("after_rst", 32'h1111_1111, 32'h2222_2222, 1'b0, 32'h3333_3333, 1'b0, 1'b0, 4'b0000);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
